mux4_rr_arbiter: RTL and testbench

MUX4_RR_ARBITER -- requirements
Module: mux4_rr_arbiter

---
 rtl/mux4_rr_arbiter.sv | 103 ++++++++++
 tb/tb_mux4_rr_arbiter.sv | 130 +++++++++++++
 2 files changed

// File: rtl/mux4_rr_arbiter.sv
// Four-way round-robin arbiter steering one data bit per requester onto a shared registered path.
// Grant and select register on the arbitration edge; y/valid follow one cycle later.
module mux4_rr_arbiter #(
    parameter int unsigned HOLD_MAX = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic [3:0] din,
    output logic [3:0] gnt,
    output logic       s0,
    output logic       s1,
    output logic       y,
    output logic       valid,
    output logic       busy
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [3:0] HMAX = 4'(HOLD_MAX);

    state_t     state;
    logic [1:0] ptr;
    logic [3:0] cnt;
    logic [1:0] cur;
    logic [3:0] others;
    logic [2:0] win_all;
    logic [2:0] win_oth;

    // Returns {found, index} of the first set bit of m searching p, p+1, p+2, p+3 (mod 4).
    function automatic logic [2:0] pick(input logic [3:0] m, input logic [1:0] p);
        logic [2:0] r;
        logic [1:0] idx;
        r = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = p + 2'(k);
            if (m[idx]) r = {1'b1, idx};
        end
        return r;
    endfunction

    assign cur  = {s0, s1};
    assign busy = (state == GRANT);

    always_comb begin
        others  = req & ~(4'b0001 << cur);
        win_all = pick(req, ptr);
        // Excluding the holder makes preemption and hand-off share one search.
        win_oth = pick(others, ptr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            gnt   <= 4'b0000;
            s0    <= 1'b0;
            s1    <= 1'b0;
            y     <= 1'b0;
            valid <= 1'b0;
            ptr   <= 2'd0;
            cnt   <= 4'd0;
        end else begin
            if (state == GRANT) begin
                y     <= din[cur];
                valid <= 1'b1;
            end else begin
                valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (win_all[2]) begin
                        state    <= GRANT;
                        gnt      <= 4'b0001 << win_all[1:0];
                        {s0, s1} <= win_all[1:0];
                        ptr      <= win_all[1:0] + 2'd1;
                        cnt      <= 4'd1;
                    end else begin
                        gnt <= 4'b0000;
                    end
                end
                GRANT: begin
                    if (req[cur] && (cnt < HMAX)) begin
                        cnt <= cnt + 4'd1;
                    end else if (win_oth[2]) begin
                        gnt      <= 4'b0001 << win_oth[1:0];
                        {s0, s1} <= win_oth[1:0];
                        ptr      <= win_oth[1:0] + 2'd1;
                        cnt      <= 4'd1;
                    end else if (req[cur]) begin
                        cnt <= 4'd1;
                    end else begin
                        state <= IDLE;
                        gnt   <= 4'b0000;
                        cnt   <= 4'd0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter: reset, rotation, hold limit, wrap, data path and mid-grant reset.
module tb_mux4_rr_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] din;
    logic [3:0] gnt;
    logic       s0;
    logic       s1;
    logic       y;
    logic       valid;
    logic       busy;

    int n_checks = 0;
    int n_fails  = 0;
    logic prev_busy = 1'b0;
    logic [3:0] exp_g;
    logic bitv;

    mux4_rr_arbiter #(.HOLD_MAX(4)) dut (
        .clk(clk), .rst(rst), .req(req), .din(din), .gnt(gnt),
        .s0(s0), .s1(s1), .y(y), .valid(valid), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [3:0] g, input logic [1:0] sel,
                           input logic v, input logic b);
        chk({tag, ".gnt"},   32'(gnt), 32'(g));
        chk({tag, ".sel"},   32'({s0, s1}), 32'(sel));
        chk({tag, ".valid"}, 32'(valid), 32'(v));
        chk({tag, ".busy"},  32'(busy), 32'(b));
    endtask

    // Cycle invariants sampled away from the active edge.
    always @(negedge clk) begin
        chk("inv_onehot", 32'($countones(gnt) <= 1), 32'd1);
        if (busy) chk("inv_sel", 32'(gnt), 32'(4'b0001 << {s0, s1}));
        if (valid) chk("inv_valid_prev_busy", 32'(prev_busy), 32'd1);
        prev_busy = busy;
    end

    initial begin
        rst = 1'b1;
        req = 4'b0000;
        din = 4'b0000;
        step();
        step();
        chk_out("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        chk("reset.y", 32'(y), 32'd0);

        // Full rotation with every requester active
        rst = 1'b0;
        req = 4'b1111;
        step(); chk_out("rot_a", 4'b0001, 2'd0, 1'b0, 1'b1);
        req = 4'b1110;
        step(); chk_out("rot_b", 4'b0010, 2'd1, 1'b1, 1'b1);
        req = 4'b1100;
        step(); chk_out("rot_c", 4'b0100, 2'd2, 1'b1, 1'b1);
        req = 4'b1000;
        step(); chk_out("rot_d", 4'b1000, 2'd3, 1'b1, 1'b1);
        req = 4'b0000;
        step(); chk_out("rot_idle", 4'b0000, 2'd3, 1'b1, 1'b0);
        step(); chk_out("rot_idle2", 4'b0000, 2'd3, 1'b0, 1'b0);

        // Wrap 3 -> 0 on hand-off
        req = 4'b1000;
        step(); chk_out("wrap_d", 4'b1000, 2'd3, 1'b0, 1'b1);
        req = 4'b0001;
        step(); chk_out("wrap_a", 4'b0001, 2'd0, 1'b1, 1'b1);
        req = 4'b0000;
        step(); chk_out("wrap_idle", 4'b0000, 2'd0, 1'b1, 1'b0);

        // Lone requester c: held past HOLD_MAX, y follows din[2] one cycle late
        req = 4'b0100;
        din = 4'b1011;
        step(); chk_out("solo_first", 4'b0100, 2'd2, 1'b0, 1'b1);
        for (int i = 1; i < 10; i++) begin
            bitv = ((i % 3) == 1);
            din  = {~bitv, bitv, ~bitv, ~bitv};
            step();
            chk_out($sformatf("solo_%0d", i), 4'b0100, 2'd2, 1'b1, 1'b1);
            chk($sformatf("solo_y_%0d", i), 32'(y), 32'(bitv));
        end
        req = 4'b0000;
        step(); chk_out("solo_drop", 4'b0000, 2'd2, 1'b1, 1'b0);

        // Two requesters alternate every HOLD_MAX cycles, never a zero grant
        req = 4'b0011;
        for (int i = 0; i < 9; i++) begin
            exp_g = (i < 4) ? 4'b0001 : ((i < 8) ? 4'b0010 : 4'b0001);
            step();
            chk($sformatf("hold_gnt_%0d", i), 32'(gnt), 32'(exp_g));
        end

        // Reset mid-grant, then search restarts at index 0
        req = 4'b0100;
        step(); chk_out("pre_rst", 4'b0100, 2'd2, 1'b1, 1'b1);
        rst = 1'b1;
        step(); chk_out("mid_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
        chk("mid_rst.y", 32'(y), 32'd0);
        rst = 1'b0;
        req = 4'b1100;
        step(); chk_out("post_rst", 4'b0100, 2'd2, 1'b0, 1'b1);
        chk("post_rst.s0", 32'(s0), 32'd1);
        chk("post_rst.s1", 32'(s1), 32'd0);

        req = 4'b0000;
        step();
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
